// File: rtl/spi_byte_rx_if.sv
// spi_byte_rx_if: received-byte valid/ready bundle.
// master drives data/dc/valid, slave returns ready.
interface spi_byte_rx_if;
  logic [7:0] data;
  logic       dc;
  logic       valid;
  logic       ready;

  modport master (
    output data, dc, valid,
    input  ready
  );

  modport slave (
    input  data, dc, valid,
    output ready
  );
endinterface

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampled SPI byte receiver, MSB first on SCLK rise.
// Optional DC capture enabled by macro SPI_RX_DC_EN.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             sdi,
  input  logic             cs_n,
`ifdef SPI_RX_DC_EN
  input  logic             dc_in,
`endif
  input  logic             clr_err,
  spi_byte_rx_if.master    rx,
  output logic             rx_overrun,
  output logic             frame_err,
  output logic             frame_active,
  output logic [CNT_W-1:0] rx_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_q, sdi_q, cs_q;
  logic sclk_d;
  logic sclk_s, sdi_s, cs_s, rise;

  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] data_q;
  logic       valid_q;

  logic start, stop, shift_en;
  logic complete, load, drop, ferr_set;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;

  // Equal-depth synchronizers, idle levels on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '1;
      sdi_q  <= '1;
      cs_q   <= '1;
      sclk_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_in};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sclk_d <= sclk_s;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end
      end
    endcase
    shift_en = (state == SHIFT) & ~cs_s & rise;
    complete = shift_en & (bit_cnt == 3'd7);
    load     = complete & (~valid_q | rx.ready);
    drop     = complete & ~load;
    ferr_set = stop & (bit_cnt != 3'd0);
  end

  assign frame_active = (state == SHIFT);

  // Shifter, holding register, counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        sr      <= {sr[5:0], sdi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (start)     rx_count <= '0;
      else if (load) rx_count <= rx_count + 1'b1;

      if (load) data_q <= {sr, sdi_s};

      if (load)                    valid_q <= 1'b1;
      else if (valid_q & rx.ready) valid_q <= 1'b0;

      if (drop)         rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;

      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign rx.data  = data_q;
  assign rx.valid = valid_q;

`ifdef SPI_RX_DC_EN
  logic [SYNC_STAGES-1:0] dc_q;
  logic dc_s;
  logic dc_r;

  assign dc_s = dc_q[SYNC_STAGES-1];

  // DC synchronizer and capture on the completing rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dc_q <= '1;
      dc_r <= 1'b0;
    end else begin
      dc_q <= {dc_q[SYNC_STAGES-2:0], dc_in};
      if (load) dc_r <= dc_s;
    end
  end

  assign rx.dc = dc_r;
`else
  assign rx.dc = 1'b0;
`endif

endmodule

// File: doc/spi_byte_rx.md
# spi_byte_rx

Synchronous SPI receiver for the OLED serial link. It is the listening end of the 8-bit SPI byte transmitter, which drives SCLK idle-high and changes SDO on SCLK falling edges. The block oversamples SCLK, SDI and CS_N in the system clock domain and shifts data in MSB-first on SCLK rising edges. Each completed byte goes to a one-entry valid/ready holding register. It serves as the bench display model and as the loopback checker for the OLED driver path.

## Interface
- SYNC_STAGES, 2: synchronizer flops per input pin (legal 2..4).
- CNT_W, 16: width of RX_COUNT.

- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- SCLK_IN  in  1  SPI clock from transmitter, idle high, asynchronous.
- SDI  in  1  serial data, MSB first, asynchronous.
- CS_N  in  1  frame select, active-low; tie low when the link has no select.
- DC_IN  in  1  OLED data/command line; present only with SPI_RX_DC_EN.
- CLR_ERR  in  1  one-cycle pulse; clears RX_OVERRUN and FRAME_ERR.
- RX_DATA  out  8  received byte.
- RX_DC  out  1  DC_IN captured with the byte (0 without the macro).
- RX_VALID  out  1  RX_DATA/RX_DC hold an unread byte.
- RX_READY  in  1  consumer accepts when RX_VALID & RX_READY.
- RX_OVERRUN  out  1  sticky: a completed byte was dropped.
- FRAME_ERR  out  1  sticky: CS_N rose with 1..7 bits received.
- FRAME_ACTIVE  out  1  FSM in SHIFT.
- RX_COUNT  out  CNT_W  bytes loaded in the current frame.

## Operation
- Sync: SCLK_IN, SDI, CS_N (and DC_IN) each pass through SYNC_STAGES flops, with equal depth so the paths stay aligned. One extra flop on synced SCLK gives `rise = sclk_s & ~sclk_d`.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT when synced CS_N = 0. On this transition, bit_cnt <= 0 and RX_COUNT <= 0.
  - SHIFT -> IDLE when synced CS_N = 1. If bit_cnt is 1..7 here, FRAME_ERR <= 1 and the partial byte is discarded.
- In SHIFT, on each `rise`: sr <= {sr[6:0], sdi_s} and bit_cnt <= bit_cnt+1 (3-bit counter).
- On a `rise` with bit_cnt = 7, the byte completes as {sr[6:0], sdi_s} and bit_cnt wraps to 0.
  - If the holding register is empty, or is being read in this cycle (RX_VALID & RX_READY): load RX_DATA and RX_DC, set RX_VALID = 1, RX_COUNT += 1 (wraps modulo 2^CNT_W).
  - Otherwise the byte is dropped, RX_OVERRUN <= 1, and RX_COUNT is unchanged.
- A read (RX_VALID & RX_READY) with no byte completing in that cycle clears RX_VALID.
- CLR_ERR clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- SCLK falling edges are ignored. Edges while in IDLE are ignored.
- Reset values: RX_DATA=0, RX_DC=0, RX_VALID=0, RX_OVERRUN=0, FRAME_ERR=0, FRAME_ACTIVE=0, RX_COUNT=0, bit_cnt=0, sr=0, state IDLE. Synchronizer flops reset to 1 (idle levels).
- Reset mid-byte discards the partial byte. If CS_N is still low, the next rising edge counts as bit 7 (the MSB). Transmitter and receiver must be reset together.

## Timing
- Input constraint: SCLK high and low phases each >= SYNC_STAGES+2 CLK periods. The transmitter's /32 divider gives 16 each.
- SDI must be stable from the SCLK falling edge through the next rising edge. This holds because the transmitter updates SDO on the falling edge.
- Latency: RX_VALID rises SYNC_STAGES+1 CLK edges after the first CLK edge that samples the 8th SCLK_IN rise high. It is 3 edges with the default.
- FRAME_ACTIVE rises SYNC_STAGES+1 edges after the first CLK edge that samples CS_N low.
- Throughput: one byte per 8 SCLK periods. The holding register accepts back-to-back bytes when RX_READY is held at 1.
- RX_DATA is stable while RX_VALID=1 and no read has occurred.

## Configuration
- SPI_RX_DC_EN defined:
  - DC_IN exists and is synchronized like SDI.
  - RX_DC is the synced DC level sampled on the completing `rise`.
- SPI_RX_DC_EN undefined:
  - No DC_IN port and no DC synchronizer.
  - RX_DC is constant 0.

## Test plan
- Single byte: CS_N low, send 8'hA5 with SCLK at CLK/32 -> RX_DATA=8'hA5, RX_VALID rises 3 CLK after the 8th rise sample, RX_COUNT=1, no flags.
- Back-to-back with RX_READY=1: send 8'h00, 8'hFF, 8'h3C -> three read handshakes in order, RX_COUNT=3, RX_OVERRUN=0.
- Overrun: RX_READY=0, send 8'h11 then 8'h22 -> RX_DATA stays 8'h11 and RX_OVERRUN=1. A CLR_ERR pulse returns RX_OVERRUN to 0.
- Partial frame: 5 bits, then CS_N high -> FRAME_ERR=1, RX_VALID stays 0. The next frame's byte 8'h81 is received correctly.
- Simultaneous: a byte completes in the same cycle as a read of the previous byte -> new byte loaded, RX_VALID stays 1, no overrun.
- With SPI_RX_DC_EN: DC_IN=0 for byte 8'hAF, DC_IN=1 for byte 8'h55 -> RX_DC 0 then 1. Then assert RST_N=0 after bit 4 -> all outputs return to reset values.
